// File: rtl/gst_audio_pkg.sv
// Shared definitions for the DMA audio playback engine: sample format and
// rate codes, the default prescaler and the signed-to-offset conversion.
package gst_audio_pkg;

    typedef enum logic [1:0] {
        FMT_STEREO8     = 2'b00,
        FMT_MONO8       = 2'b01,
        FMT_STEREO16    = 2'b10,
        FMT_STEREO8_ALT = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        RATE_6K25 = 2'b00,
        RATE_12K5 = 2'b01,
        RATE_25K  = 2'b10,
        RATE_50K  = 2'b11
    } rate_e;

    // 32 MHz / 640 = 50 kHz base tick
    localparam int PRESCALE_DEFAULT = 640;

    // Two's complement to offset binary: flip the sign bit.
    // 8-bit samples are passed left-justified in the 16-bit word.
    function automatic logic [15:0] to_offset16(input logic [15:0] s);
        return {~s[15], s[14:0]};
    endfunction

endpackage

// File: rtl/gst_dma_audio_if.sv
// RAM-side sound DMA bus: load strobe, data word and request back to the MCU.
interface gst_dma_audio_if;
    logic        SLOAD_N;
    logic [15:0] MDIN;
    logic        SREQ;

    modport master (output SLOAD_N, output MDIN, input SREQ);
    modport slave  (input SLOAD_N, input MDIN, output SREQ);
endinterface

// File: rtl/gst_audio_fifo.sv
// Sample word FIFO with level counter and flush.
// With GST_DMA_AUDIO_16BIT_EN defined a second read port returns the word
// after the head so a stereo16 frame can be consumed in one cycle.
// Reads are asynchronous so a word written at one edge can be consumed by a
// sample tick evaluated in the very next cycle.
module gst_audio_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [15:0]   wr_data_i,
    input  logic [1:0]    pop_cnt_i,
    output logic [15:0]   rd_data0_o,
`ifdef GST_DMA_AUDIO_16BIT_EN
    output logic [15:0]   rd_data1_o,
`endif
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int DEPTH = 1 << AW;
    localparam int LW    = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          accept;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    assign rd_data0_o = mem[rd_ptr_q];
`ifdef GST_DMA_AUDIO_16BIT_EN
    assign rd_data1_o = mem[rd_ptr_q + AW'(1)];
`endif

    // Next-state pointers/level; a full FIFO still accepts a word when a pop
    // frees a slot in the same cycle. The caller only pops what is present.
    always_comb begin
        accept   = wr_en_i && !flush_i && (!full_o || (pop_cnt_i != 2'd0));
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            rd_ptr_d = rd_ptr_q + AW'(pop_cnt_i);
            level_d  = level_q + LW'(accept) - LW'(pop_cnt_i);
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents need no reset, the level guards them
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/gst_dma_audio.sv
// STE/Falcon-class DMA sound playback engine: buffers words loaded on the
// falling edge of SLOAD_N and drains them as stereo8 / mono8 / stereo16
// frames at a rate derived from clk32.
// Optional feature macro: GST_DMA_AUDIO_16BIT_EN enables the stereo16 format.
module gst_dma_audio
    import gst_audio_pkg::*;
#(
    parameter int FIFO_ADDR_BITS = 3,
    parameter int OUT_W          = 16,
    parameter int PRESCALE       = PRESCALE_DEFAULT
) (
    input  logic                    clk32,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    flush,
    input  logic [1:0]              rate,
    input  logic [1:0]              fmt,
    gst_dma_audio_if.slave          dma,
    output logic [OUT_W-1:0]        audio_left,
    output logic [OUT_W-1:0]        audio_right,
    output logic                    sample_strobe,
    output logic [FIFO_ADDR_BITS:0] level,
    output logic                    underrun,
    output logic                    overflow,
    input  logic                    flag_clr
);

    localparam int DEPTH = 1 << FIFO_ADDR_BITS;
    localparam int LW    = FIFO_ADDR_BITS + 1;
    localparam int PW    = $clog2(PRESCALE);
    localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

    logic          sload_q;
    logic [PW-1:0] presc_q;
    logic [2:0]    rate_cnt_q;
    logic          sel_q, sel_d;
    logic [OUT_W-1:0] left_q, right_q;
    logic          strobe_q;
    logic          underrun_q, overflow_q;

    logic          load_fall;
    logic          base_tick, rate_hit, sample_tick;
    fmt_e          fmt_eff;
    logic          tick_act, have_data, consume, under_evt, ovf_evt;
    logic [1:0]    pop_cnt;
    logic [7:0]    mono_byte;
    logic [15:0]   left_full, right_full;

    logic [15:0]   rd_data0;
`ifdef GST_DMA_AUDIO_16BIT_EN
    logic [15:0]   rd_data1;
`endif
    logic [LW-1:0] fifo_level;
    logic          fifo_full, fifo_empty;

    assign load_fall = sload_q && !dma.SLOAD_N;

    gst_audio_fifo #(.AW(FIFO_ADDR_BITS)) u_fifo (
        .clk        (clk32),
        .srst       (reset),
        .flush_i    (flush),
        .wr_en_i    (load_fall),
        .wr_data_i  (dma.MDIN),
        .pop_cnt_i  (pop_cnt),
        .rd_data0_o (rd_data0),
`ifdef GST_DMA_AUDIO_16BIT_EN
        .rd_data1_o (rd_data1),
`endif
        .level_o    (fifo_level),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Load strobe history for falling-edge detection
    always_ff @(posedge clk32) begin
        if (reset) sload_q <= 1'b1;
        else       sload_q <= dma.SLOAD_N;
    end

    // Base-tick prescaler and free-running rate divider
    always_ff @(posedge clk32) begin
        if (reset) begin
            presc_q    <= '0;
            rate_cnt_q <= '0;
        end else begin
            presc_q <= (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + PW'(1);
            if (base_tick) rate_cnt_q <= rate_cnt_q + 3'd1;
        end
    end

    assign base_tick = (presc_q == '0);

    // Select every 1st/2nd/4th/8th base tick depending on rate
    always_comb begin
        rate_hit = (rate_cnt_q == 3'b000);
        case (rate_e'(rate))
            RATE_50K:  rate_hit = 1'b1;
            RATE_25K:  rate_hit = !rate_cnt_q[0];
            RATE_12K5: rate_hit = (rate_cnt_q[1:0] == 2'b00);
            default:   rate_hit = (rate_cnt_q == 3'b000);
        endcase
    end

    assign sample_tick = base_tick && rate_hit;

    // Fold unsupported/reserved format codes onto stereo8
    always_comb begin
        fmt_eff = FMT_STEREO8;
        case (fmt_e'(fmt))
            FMT_MONO8:    fmt_eff = FMT_MONO8;
`ifdef GST_DMA_AUDIO_16BIT_EN
            FMT_STEREO16: fmt_eff = FMT_STEREO16;
`endif
            default:      fmt_eff = FMT_STEREO8;
        endcase
    end

    // Frame extraction, pop count and flag events for the current tick
    always_comb begin
        tick_act  = sample_tick && enable && !flush;
        have_data = !fifo_empty;
`ifdef GST_DMA_AUDIO_16BIT_EN
        if (fmt_eff == FMT_STEREO16) have_data = (fifo_level >= LW'(2));
`endif
        consume    = tick_act && have_data;
        under_evt  = tick_act && !have_data;
        mono_byte  = sel_q ? rd_data0[7:0] : rd_data0[15:8];
        left_full  = to_offset16({rd_data0[15:8], 8'h00});
        right_full = to_offset16({rd_data0[7:0], 8'h00});
        pop_cnt    = {1'b0, consume};
        case (fmt_eff)
            FMT_MONO8: begin
                left_full  = to_offset16({mono_byte, 8'h00});
                right_full = left_full;
                pop_cnt    = {1'b0, consume && sel_q};
            end
`ifdef GST_DMA_AUDIO_16BIT_EN
            FMT_STEREO16: begin
                left_full  = to_offset16(rd_data0);
                right_full = to_offset16(rd_data1);
                pop_cnt    = consume ? 2'd2 : 2'd0;
            end
`endif
            default: ;
        endcase
        // a dropped load only counts when nothing frees a slot this cycle
        ovf_evt = load_fall && fifo_full && (pop_cnt == 2'd0) && !flush;
        sel_d   = sel_q;
        if (flush || fmt_eff != FMT_MONO8) sel_d = 1'b0;
        else if (consume)                   sel_d = !sel_q;
    end

    // Output sample registers and update strobe
    always_ff @(posedge clk32) begin
        if (reset) begin
            left_q   <= MIDSCALE;
            right_q  <= MIDSCALE;
            strobe_q <= 1'b0;
            sel_q    <= 1'b0;
        end else begin
            strobe_q <= consume;
            sel_q    <= sel_d;
            if (consume) begin
                left_q  <= left_full[15 -: OUT_W];
                right_q <= right_full[15 -: OUT_W];
            end
        end
    end

    // Sticky status flags; a new event beats a simultaneous clear
    always_ff @(posedge clk32) begin
        if (reset) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (under_evt)     underrun_q <= 1'b1;
            else if (flag_clr) underrun_q <= 1'b0;
            if (ovf_evt)       overflow_q <= 1'b1;
            else if (flag_clr) overflow_q <= 1'b0;
        end
    end

    // Request only while room remains for one more word already in flight
    assign dma.SREQ = (fifo_level < LW'(DEPTH - 1));

    assign audio_left    = left_q;
    assign audio_right   = right_q;
    assign sample_strobe = strobe_q;
    assign level         = fifo_level;
    assign underrun      = underrun_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_gst_dma_audio.sv
// Directed bench for gst_dma_audio (depth 8, 16-bit outputs, prescale 640).
module tb_gst_dma_audio;

    logic        clk32 = 1'b0;
    logic        reset, enable, flush, flag_clr;
    logic [1:0]  rate, fmt;
    logic [15:0] audio_left, audio_right;
    logic        sample_strobe;
    logic [3:0]  level;
    logic        underrun, overflow;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk32 = ~clk32;

    gst_dma_audio_if dma_if ();

    gst_dma_audio #(
        .FIFO_ADDR_BITS (3),
        .OUT_W          (16),
        .PRESCALE       (640)
    ) dut (
        .clk32         (clk32),
        .reset         (reset),
        .enable        (enable),
        .flush         (flush),
        .rate          (rate),
        .fmt           (fmt),
        .dma           (dma_if),
        .audio_left    (audio_left),
        .audio_right   (audio_right),
        .sample_strobe (sample_strobe),
        .level         (level),
        .underrun      (underrun),
        .overflow      (overflow),
        .flag_clr      (flag_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // called at a negedge; write commits at the following posedge
    task automatic load(input logic [15:0] w);
        dma_if.MDIN    = w;
        dma_if.SLOAD_N = 1'b0;
        @(negedge clk32);
        dma_if.SLOAD_N = 1'b1;
        @(negedge clk32);
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        @(negedge clk32);
        flag_clr = 1'b0;
    endtask

    task automatic wait_strobe(input int max, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk32);
            cnt++;
        end while (!sample_strobe && cnt < max);
        check("strobe_seen", sample_strobe, 1'b1);
    endtask

    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk32);
            if (sample_strobe) cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0; flag_clr = 1'b0;
        rate = 2'b11; fmt = 2'b00;
        dma_if.SLOAD_N = 1'b1; dma_if.MDIN = 16'h0000;
        repeat (3) @(negedge clk32);

        // reset state
        check("rst_left",   audio_left, 16'h8000);
        check("rst_right",  audio_right, 16'h8000);
        check("rst_level",  level, 4'd0);
        check("rst_sreq",   dma_if.SREQ, 1'b1);
        check("rst_under",  underrun, 1'b0);
        check("rst_over",   overflow, 1'b0);
        check("rst_strobe", sample_strobe, 1'b0);
        reset = 1'b0;
        @(negedge clk32);

        // stereo8 at 50 kHz
        load(16'h7F80);
        check("s8_level_load", level, 4'd1);
        enable = 1'b1;
        wait_strobe(700, n);
        enable = 1'b0;
        check("s8_left",  audio_left, 16'hFF00);
        check("s8_right", audio_right, 16'h0000);
        check("s8_level", level, 4'd0);
        @(negedge clk32);
        check("s8_one_strobe", sample_strobe, 1'b0);

        // mono8: high byte, then low byte, pop after the second
        fmt = 2'b01;
        load(16'h0102);
        enable = 1'b1;
        wait_strobe(700, n);
        check("m8_left0",  audio_left, 16'h8100);
        check("m8_right0", audio_right, 16'h8100);
        check("m8_level0", level, 4'd1);
        wait_strobe(700, n);
        enable = 1'b0;
        check("m8_interval", n, 640);
        check("m8_left1",  audio_left, 16'h8200);
        check("m8_right1", audio_right, 16'h8200);
        check("m8_level1", level, 4'd0);

        // underrun on empty FIFO, outputs hold, then clear
        fmt = 2'b00;
        enable = 1'b1;
        count_strobes(700, n);
        enable = 1'b0;
        check("ur_no_strobe", n, 0);
        check("ur_flag",      underrun, 1'b1);
        check("ur_hold",      audio_left, 16'h8200);
        pulse_clr();
        check("ur_cleared",   underrun, 1'b0);

`ifdef GST_DMA_AUDIO_16BIT_EN
        // stereo16: one word is not enough
        fmt = 2'b10;
        load(16'h0000);
        enable = 1'b1;
        count_strobes(700, n);
        enable = 1'b0;
        check("s16_short_strobes", n, 0);
        check("s16_short_under",   underrun, 1'b1);
        check("s16_short_hold",    audio_left, 16'h8200);
        check("s16_short_level",   level, 4'd1);
        pulse_clr();
        load(16'hFFFF);
        enable = 1'b1;
        wait_strobe(700, n);
        enable = 1'b0;
        check("s16_left",  audio_left, 16'h8000);
        check("s16_right", audio_right, 16'h7FFF);
        check("s16_level", level, 4'd0);
`else
        // fmt 10 falls back to stereo8
        fmt = 2'b10;
        load(16'h7F80);
        enable = 1'b1;
        wait_strobe(700, n);
        enable = 1'b0;
        check("f10_left",  audio_left, 16'hFF00);
        check("f10_right", audio_right, 16'h0000);
        check("f10_level", level, 4'd0);
`endif

        // fill to full, overflow, clear
        fmt = 2'b00;
        for (int i = 1; i <= 9; i++) begin
            load(16'(16'h1000 + i));
            if (i == 6) begin
                check("full_sreq6",  dma_if.SREQ, 1'b1);
                check("full_level6", level, 4'd6);
            end
            if (i == 7) begin
                check("full_sreq7",  dma_if.SREQ, 1'b0);
                check("full_level7", level, 4'd7);
            end
            if (i == 8) check("full_level8", level, 4'd8);
            if (i == 9) begin
                check("ovf_flag",  overflow, 1'b1);
                check("ovf_level", level, 4'd8);
            end
        end
        pulse_clr();
        check("ovf_cleared", overflow, 1'b0);

        // pop one, refill, then land a load on the next tick at level 8
        enable = 1'b1;
        wait_strobe(700, n);
        check("pop_level", level, 4'd7);
        check("pop_left",  audio_left, 16'h9000);
        check("pop_right", audio_right, 16'h8100);
        load(16'h2000);
        check("refill_level", level, 4'd8);
        repeat (637) @(negedge clk32);
        dma_if.MDIN    = 16'h2001;
        dma_if.SLOAD_N = 1'b0;
        @(negedge clk32);
        dma_if.SLOAD_N = 1'b1;
        enable = 1'b0;
        check("both_strobe", sample_strobe, 1'b1);
        check("both_level",  level, 4'd8);
        check("both_ovf",    overflow, 1'b0);
        check("both_right",  audio_right, 16'h8200);

        // flush beats a simultaneous load
        flush = 1'b1;
        dma_if.MDIN    = 16'h3000;
        dma_if.SLOAD_N = 1'b0;
        @(negedge clk32);
        flush = 1'b0;
        dma_if.SLOAD_N = 1'b1;
        check("flush_level", level, 4'd0);
        check("flush_sreq",  dma_if.SREQ, 1'b1);
        @(negedge clk32);

        // 6.25 kHz with a filled FIFO
        rate = 2'b00;
        for (int i = 0; i < 8; i++) load(16'(16'h4000 + i));
        check("r00_fill", level, 4'd8);
        enable = 1'b1;
        wait_strobe(5200, n);
        wait_strobe(5200, n);
        enable = 1'b0;
        check("r00_interval", n, 5120);
        check("r00_level",    level, 4'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
